// File: rtl/philv_mem_stage.sv
// philv_mem_stage: data-memory access stage of the multicycle core.
// Takes the effective address, store data and funct3 from execute and runs
// one access on a single-port, word-addressed memory using a
// req/gnt/rvalid handshake. It returns extended load data or store
// completion to writeback, and flags misaligned, illegal-size and
// timed-out accesses.
//
// state | meaning
// IDLE  | ready for a new access (req_ready = 1)
// REQ   | mem_req held with stable address/lanes until mem_gnt
// WAIT  | load granted; waiting for mem_rvalid or timeout
// DONE  | one-cycle resp_valid pulse
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_ready       access handshake from execute
//   req_store/req_funct3      access kind and size
//   req_addr/req_wdata        byte address, store data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   memory request side
//   mem_gnt/mem_rvalid/mem_rdata               memory response side
//   resp_valid/resp_rdata/resp_err/resp_err_code  completion to writeback
module philv_mem_stage #(
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [2:0]           req_funct3,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  output logic                 resp_valid,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [1:0]           resp_err_code
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [1:0]  ERR_NONE  = 2'b00;
  localparam logic [1:0]  ERR_ALIGN = 2'b01;
  localparam logic [1:0]  ERR_SIZE  = 2'b10;
  localparam logic [1:0]  ERR_TOUT  = 2'b11;
  // Timeout fires on the TIMEOUT-th WAIT cycle (counter starts at 0).
  localparam logic [31:0] TO_LAST   = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t      state, state_n;
  logic [31:0] addr_q;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] cnt;

  logic        illegal, misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;
  logic        fin_load;
  logic        fin_err;
  logic [1:0]  fin_code;

  // Size/alignment decode on the incoming request.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_store;
      default:                illegal = 1'b1;
    endcase
    if (req_funct3[1:0] == 2'b01) misaligned = req_addr[0];
    if (req_funct3 == 3'b010)     misaligned = (req_addr[1:0] != 2'b00);
  end

  // Store lane placement; loads carry no byte enables.
  always_comb begin
    be_n    = 4'b0000;
    wdata_n = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << req_addr[1:0];
        wdata_n = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << req_addr[1:0];
        wdata_n = {2{req_wdata[15:0]}};
      end
      default: be_n = 4'b1111;
    endcase
    if (!req_store) be_n = 4'b0000;
  end

  // Load extraction from the returned word.
  always_comb begin
    rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'd0, rd_shift[7:0]};
      3'b101:  load_ext = {16'd0, rd_shift[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next state plus the response to latch on entry to DONE.
  always_comb begin
    state_n  = state;
    fin_load = 1'b0;
    fin_err  = 1'b0;
    fin_code = ERR_NONE;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            state_n  = DONE;
            fin_err  = 1'b1;
            fin_code = ERR_SIZE;
          end else if (misaligned) begin
            state_n  = DONE;
            fin_err  = 1'b1;
            fin_code = ERR_ALIGN;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) state_n = store_q ? DONE : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_n  = DONE;
          fin_load = 1'b1;
        end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
          state_n  = DONE;
          fin_err  = 1'b1;
          fin_code = ERR_TOUT;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      store_q       <= 1'b0;
      f3_q          <= 3'b000;
      mem_be        <= 4'b0000;
      mem_wdata     <= '0;
      cnt           <= '0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      resp_err_code <= ERR_NONE;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q    <= req_addr;
        store_q   <= req_store;
        f3_q      <= req_funct3;
        mem_be    <= be_n;
        mem_wdata <= wdata_n;
      end
      if (state == REQ && mem_gnt) cnt <= '0;
      else if (state == WAIT)      cnt <= cnt + 32'd1;
      if (state_n == DONE && state != DONE) begin
        resp_rdata    <= fin_load ? load_ext : 32'd0;
        resp_err      <= fin_err;
        resp_err_code <= fin_code;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign mem_req    = (state == REQ);
  assign mem_we     = (state == REQ) && store_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign resp_valid = (state == DONE);

endmodule

// File: tb/tb_philv_mem_stage.sv
module tb_philv_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err_code;

  int total = 0;
  int bad   = 0;

  philv_mem_stage #(.BUS_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_err_code(resp_err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    bit          store;
    bit [2:0]    f3;
    bit [31:0]   addr;
    bit [31:0]   wdata;
    int          gnt_dly;   // extra REQ cycles before gnt
    int          rv_dly;    // extra WAIT cycles before rvalid; -1 = never
    bit          spur;      // also pulse rvalid (garbage) in the gnt cycle
    bit [31:0]   rdata;
    bit [31:0]   exp_rdata;
    bit          exp_err;
    bit [1:0]    exp_code;
    bit [3:0]    exp_be;
    bit [31:0]   exp_wdata;
    int          exp_cyc;   // cycle of resp_valid, accept = cycle 0
    int          exp_reqs;  // cycles with mem_req high
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    int c, reqs, gnt_c, resp_c;
    bit stable, done;
    logic [31:0] a0, w0, r_rd;
    logic [3:0]  b0;
    logic        we0, r_err;
    logic [1:0]  r_code;
    reqs = 0; gnt_c = -1; resp_c = -1; stable = 1'b1; done = 1'b0;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0; r_rd = '0; r_err = 1'b0; r_code = '0;
    chk({v.name, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_DEAD;
    step();
    req_valid = 1'b0;
    c = 1;
    while (c < 40 && !done) begin
      if (resp_valid) begin
        resp_c = c; r_rd = resp_rdata; r_err = resp_err; r_code = resp_err_code;
        done = 1'b1;
      end
      if (mem_req) begin
        reqs++;
        if (reqs == 1) begin
          a0 = mem_addr; w0 = mem_wdata; b0 = mem_be; we0 = mem_we;
        end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_be !== b0 || mem_we !== we0) begin
          stable = 1'b0;
        end
      end
      mem_gnt = mem_req && (reqs - 1 == v.gnt_dly);
      if (mem_gnt) gnt_c = c;
      mem_rvalid = 1'b0; mem_rdata = 32'hBAD0_BAD0;
      if (!done && !v.store && gnt_c >= 0 && v.rv_dly >= 0 && c == gnt_c + 1 + v.rv_dly) begin
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
      end else if (v.spur && gnt_c == c) begin
        mem_rvalid = 1'b1;
      end
      if (!done) begin
        step();
        c++;
      end
    end
    chk({v.name, " resp_cycle"}, 32'(resp_c), 32'(v.exp_cyc));
    chk({v.name, " resp_rdata"}, r_rd, v.exp_rdata);
    chk({v.name, " resp_err"}, 32'(r_err), 32'(v.exp_err));
    chk({v.name, " err_code"}, 32'(r_code), 32'(v.exp_code));
    chk({v.name, " req_cycles"}, 32'(reqs), 32'(v.exp_reqs));
    if (v.exp_reqs > 0) begin
      chk({v.name, " mem_addr"}, a0, {v.addr[31:2], 2'b00});
      chk({v.name, " mem_be"}, 32'(b0), 32'(v.exp_be));
      chk({v.name, " mem_we"}, 32'(we0), 32'(v.store));
      chk({v.name, " held"}, 32'(stable), 32'd1);
      if (v.store) chk({v.name, " mem_wdata"}, w0, v.exp_wdata);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();
    chk({v.name, " pulse_end"}, 32'(resp_valid), 32'd0);
    chk({v.name, " back_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    //          name    st f3     addr         wdata        gd rd  sp rdata         exp_rdata     err code be       exp_wdata     cyc reqs
    vecs.push_back('{"lb_neg", 0, 3'b000, 32'h1003, 32'h0,        0, 0, 0, 32'h80FF_1234, 32'hFFFF_FF80, 0, 2'b00, 4'b0000, 32'h0,         3, 1});
    vecs.push_back('{"lhu",    0, 3'b101, 32'h2002, 32'h0,        0, 0, 0, 32'hBEEF_0000, 32'h0000_BEEF, 0, 2'b00, 4'b0000, 32'h0,         3, 1});
    vecs.push_back('{"lh",     0, 3'b001, 32'h2002, 32'h0,        0, 0, 0, 32'hBEEF_0000, 32'hFFFF_BEEF, 0, 2'b00, 4'b0000, 32'h0,         3, 1});
    vecs.push_back('{"sb_dly", 1, 3'b000, 32'h3001, 32'hA5,       2, 0, 0, 32'h0,         32'h0,         0, 2'b00, 4'b0010, 32'hA5A5_A5A5, 4, 3});
    vecs.push_back('{"lw_mis", 0, 3'b010, 32'h4002, 32'h0,        0, 0, 0, 32'h0,         32'h0,         1, 2'b01, 4'b0000, 32'h0,         1, 0});
    vecs.push_back('{"f3_011", 0, 3'b011, 32'h4000, 32'h0,        0, 0, 0, 32'h0,         32'h0,         1, 2'b10, 4'b0000, 32'h0,         1, 0});
    vecs.push_back('{"sh_hi",  1, 3'b001, 32'h5002, 32'h1234_CAFE,0, 0, 0, 32'h0,         32'h0,         0, 2'b00, 4'b1100, 32'hCAFE_CAFE, 2, 1});
    vecs.push_back('{"sw",     1, 3'b010, 32'h6000, 32'hDEAD_BEEF,0, 0, 0, 32'h0,         32'h0,         0, 2'b00, 4'b1111, 32'hDEAD_BEEF, 2, 1});
    vecs.push_back('{"lbu_sl", 0, 3'b100, 32'h7001, 32'h0,        1, 2, 0, 32'h1122_8344, 32'h0000_0083, 0, 2'b00, 4'b0000, 32'h0,         6, 2});
    vecs.push_back('{"lw_spur",0, 3'b010, 32'h8000, 32'h0,        0, 0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 2'b00, 4'b0000, 32'h0,         3, 1});
    vecs.push_back('{"lw_tout",0, 3'b010, 32'h9000, 32'h0,        0, -1,1, 32'h0,         32'h0,         1, 2'b11, 4'b0000, 32'h0,         6, 1});
    vecs.push_back('{"sbu_st", 1, 3'b100, 32'hA000, 32'h0,        0, 0, 0, 32'h0,         32'h0,         1, 2'b10, 4'b0000, 32'h0,         1, 0});
    vecs.push_back('{"sh_mis", 1, 3'b001, 32'h5001, 32'h0,        0, 0, 0, 32'h0,         32'h0,         1, 2'b01, 4'b0000, 32'h0,         1, 0});
    vecs.push_back('{"lb_pos", 0, 3'b000, 32'h1000, 32'h0,        0, 0, 0, 32'h0000_007F, 32'h0000_007F, 0, 2'b00, 4'b0000, 32'h0,         3, 1});

    #12;
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", {30'd0, resp_err_code} | 32'(resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while an access sits in REQ: abandoned with no response.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'hB000; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();
    req_valid = 1'b0;
    chk("midrst in_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst ready", 32'(req_ready), 32'd1);
    chk("midrst resp_valid", 32'(resp_valid), 32'd0);
    step();
    rst = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        step();
        if (resp_valid || mem_req) seen = 1'b1;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("midrst quiet", 32'(seen), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
